// File: rtl/grid_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : grid_io_pkg
//  Purpose  : Shared constants and helpers for the configurable IO grid tile.
//             Holds the per-subtile configuration width, the index of each
//             mode bit inside a subtile's configuration word, and a helper
//             that sizes the serial configuration chain.
//  Revision : 1.0  initial release
// ============================================================================
package grid_io_pkg;

    // Configuration bits carried by each IO subtile.
    localparam int CFG_BITS = 3;

    // Position of each mode bit inside a subtile configuration word.
    localparam int DIR_IDX  = 0;   // 1 = pad is an output, 0 = pad is an input
    localparam int OREG_IDX = 1;   // output path taken from the registered copy
    localparam int IREG_IDX = 2;   // input path taken from the registered copy

    // Number of stages in the whole configuration chain.
    function automatic int total_stages(input int num_subtile, input int cfg_bits);
        return num_subtile * cfg_bits;
    endfunction

endpackage : grid_io_pkg
`default_nettype wire

// File: rtl/grid_io_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : grid_io_param_if
//  Purpose  : Bundles the configuration-chain handshake and the fabric-side
//             data buses of the IO grid tile.
//  Signals  : ccff_en    - configuration shift enable
//             ccff_head  - serial configuration data in
//             ccff_tail  - serial configuration data out
//             cfg_done   - complete configuration present, pads released
//             io_outpad  - fabric-to-pad data, one bit per subtile
//             io_inpad   - pad-to-fabric data, one bit per subtile
//  Modports : master drives the chain and fabric outputs, slave is the tile.
//  Revision : 1.0  initial release
// ============================================================================
interface grid_io_param_if #(
    parameter int NUM_SUBTILE = 8
);
    logic                   ccff_en;
    logic                   ccff_head;
    logic                   ccff_tail;
    logic                   cfg_done;
    logic [NUM_SUBTILE-1:0] io_outpad;
    logic [NUM_SUBTILE-1:0] io_inpad;

    modport master (
        output ccff_en,
        output ccff_head,
        output io_outpad,
        input  ccff_tail,
        input  cfg_done,
        input  io_inpad
    );

    modport slave (
        input  ccff_en,
        input  ccff_head,
        input  io_outpad,
        output ccff_tail,
        output cfg_done,
        output io_inpad
    );

endinterface : grid_io_param_if
`default_nettype wire

// File: rtl/grid_io_subtile.sv
`default_nettype none
// ============================================================================
//  Module   : grid_io_subtile
//  Purpose  : One bidirectional IO slot. Holds its slice of the serial
//             configuration chain, a registered copy of the outgoing and of
//             the incoming pad data, the path-select muxes and the pad
//             tristate driver.
//  Ports    : clk, rst      - configuration/datapath clock, sync reset
//             i_shift_en    - advance the configuration chain
//             i_chain       - chain input from the previous stage
//             o_chain       - last configuration stage of this slot
//             i_cfg_done    - configuration valid; low forces isolation
//             i_outpad      - fabric data heading to the pad
//             o_inpad       - pad data heading to the fabric
//             io_pad        - bidirectional pad
//  Revision : 1.0  initial release
// ============================================================================
module grid_io_subtile
    import grid_io_pkg::*;
#(
    parameter int CFG_BITS = grid_io_pkg::CFG_BITS
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_shift_en,
    input  wire  i_chain,
    output logic o_chain,
    input  wire  i_cfg_done,
    input  wire  i_outpad,
    output logic o_inpad,
    inout  wire  io_pad
);

    logic [CFG_BITS-1:0] r_cfg;
    logic                r_out_q;
    logic                r_in_q;

    logic                w_dir;
    logic                w_oreg;
    logic                w_ireg;
    logic                w_pad_oe;
    logic                w_pad_val;

    // Stage 0 takes the chain input; every later stage takes its predecessor.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg <= '0;
        end else if (i_shift_en) begin
            r_cfg <= {r_cfg[CFG_BITS-2:0], i_chain};
        end
    end

    assign o_chain = r_cfg[CFG_BITS-1];

    // Data registers run every cycle; configuration only picks which copy
    // reaches the pad or the fabric.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q <= 1'b0;
            r_in_q  <= 1'b0;
        end else begin
            r_out_q <= i_outpad;
            r_in_q  <= io_pad;
        end
    end

    assign w_dir  = r_cfg[DIR_IDX];
    assign w_oreg = r_cfg[OREG_IDX];
    assign w_ireg = r_cfg[IREG_IDX];

    // An incomplete configuration must never drive the pad or leak pad data.
    assign w_pad_oe  = i_cfg_done & w_dir;
    assign w_pad_val = w_oreg ? r_out_q : i_outpad;
    assign io_pad    = w_pad_oe ? w_pad_val : 1'bz;

    assign o_inpad = (i_cfg_done & ~w_dir) ? (w_ireg ? r_in_q : io_pad) : 1'b0;

endmodule : grid_io_subtile
`default_nettype wire

// File: rtl/grid_io_param.sv
`default_nettype none
// ============================================================================
//  Module   : grid_io_param
//  Purpose  : Parameterised IO grid tile. NUM_SUBTILE bidirectional IO slots
//             share one serial configuration chain of NUM_SUBTILE*CFG_BITS
//             stages. A shift counter tracks whether a complete load has been
//             shifted in; until it has, and while shifting, every pad is
//             isolated.
//  Ports    : prog_clk            - single clock for chain and datapath
//             pReset              - synchronous active-high reset
//             io (slave modport)  - ccff_en, ccff_head, ccff_tail, cfg_done,
//                                   io_outpad, io_inpad
//             gfpga_pad_GPIO_PAD  - bidirectional pads, bit i = subtile i
//  Revision : 1.0  initial release
// ============================================================================
module grid_io_param #(
    parameter int NUM_SUBTILE = 8,
    parameter int CFG_BITS    = grid_io_pkg::CFG_BITS
) (
    input  wire                    prog_clk,
    input  wire                    pReset,
    grid_io_param_if.slave         io,
    inout  wire [NUM_SUBTILE-1:0]  gfpga_pad_GPIO_PAD
);
    import grid_io_pkg::*;

    localparam int TOTAL = total_stages(NUM_SUBTILE, CFG_BITS);
    localparam int CNT_W = $clog2(TOTAL + 1);

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ccff_en_q;
    logic                   r_cfg_done;

    logic [NUM_SUBTILE:0]   w_chain;
    logic [NUM_SUBTILE-1:0] w_outpad;
    logic [NUM_SUBTILE-1:0] w_inpad;

    // ------------------------------------------------------------------
    // Load tracking. A rising edge of ccff_en starts a fresh load and that
    // cycle already counts as its first shift. The counter saturates so an
    // overshift still reads as a complete load.
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_cnt       <= '0;
            r_ccff_en_q <= 1'b0;
            r_cfg_done  <= 1'b0;
        end else begin
            r_ccff_en_q <= io.ccff_en;
            if (io.ccff_en) begin
                if (!r_ccff_en_q) begin
                    r_cnt <= c_cnt_one;
                end else if (r_cnt != c_cnt_full) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
            // Any shifting cycle drops cfg_done, restoring isolation.
            r_cfg_done <= (r_cnt == c_cnt_full) && !io.ccff_en;
        end
    end

    // ------------------------------------------------------------------
    // Chain stitching: subtile 0 holds the lowest stages, the last
    // subtile's final stage is the chain output.
    // ------------------------------------------------------------------
    assign w_chain[0]  = io.ccff_head;
    assign w_outpad    = io.io_outpad;

    generate
        for (genvar g = 0; g < NUM_SUBTILE; g++) begin : g_subtile
            grid_io_subtile #(
                .CFG_BITS   (CFG_BITS)
            ) u_subtile (
                .clk        (prog_clk),
                .rst        (pReset),
                .i_shift_en (io.ccff_en),
                .i_chain    (w_chain[g]),
                .o_chain    (w_chain[g+1]),
                .i_cfg_done (r_cfg_done),
                .i_outpad   (w_outpad[g]),
                .o_inpad    (w_inpad[g]),
                .io_pad     (gfpga_pad_GPIO_PAD[g])
            );
        end
    endgenerate

    assign io.ccff_tail = w_chain[NUM_SUBTILE];
    assign io.cfg_done  = r_cfg_done;
    assign io.io_inpad  = w_inpad;

endmodule : grid_io_param
`default_nettype wire

// File: tb/tb_grid_io_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grid_io_param
//  Purpose  : Self-checking bench for grid_io_param with 8 subtiles. The
//             configuration chain is tracked by a queue of bits that have
//             entered the chain but not yet left through ccff_tail.
//  Revision : 1.0  initial release
// ============================================================================
module tb_grid_io_param;

    localparam int NS  = 8;
    localparam int TOT = 24;

    logic           prog_clk = 1'b0;
    logic           pReset;
    logic [NS-1:0]  tb_oe;
    logic [NS-1:0]  tb_val;
    wire  [NS-1:0]  gpio_pad;

    int n_checks = 0;
    int n_errors = 0;

    // Bits shifted into the chain, oldest first, not yet seen on ccff_tail.
    bit tail_q[$];

    always #5 prog_clk = ~prog_clk;

    grid_io_param_if #(.NUM_SUBTILE(NS)) io ();

    generate
        for (genvar g = 0; g < NS; g++) begin : g_tb_pad
            assign gpio_pad[g] = tb_oe[g] ? tb_val[g] : 1'bz;
        end
    endgenerate

    grid_io_param #(
        .NUM_SUBTILE        (NS),
        .CFG_BITS           (3)
    ) dut (
        .prog_clk           (prog_clk),
        .pReset             (pReset),
        .io                 (io),
        .gfpga_pad_GPIO_PAD (gpio_pad)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Shift one bit; the bit now at the chain output is the oldest pending one.
    task automatic shift_bit(input bit b);
        io.ccff_en   = 1'b1;
        io.ccff_head = b;
        tail_q.push_back(b);
        tick();
        check("ccff_tail", {31'd0, io.ccff_tail}, {31'd0, tail_q.pop_front()});
    endtask

    // With the tile isolated, no pad may be driven and io_inpad stays zero.
    // The bench pulls every pad low against io_outpad all ones: a leaking
    // output driver would show up as a high pad.
    task automatic check_isolated(input string tag);
        logic [NS-1:0] s_out, s_oe, s_val;
        s_out = io.io_outpad;
        s_oe  = tb_oe;
        s_val = tb_val;
        io.io_outpad = '1;
        tb_oe        = '1;
        tb_val       = '0;
        #1;
        check({tag, "_pad_z"}, {24'd0, gpio_pad}, 32'd0);
        check({tag, "_inpad_lo"}, {24'd0, io.io_inpad}, 32'd0);
        tb_val = '1;
        #1;
        check({tag, "_inpad_hi"}, {24'd0, io.io_inpad}, 32'd0);
        io.io_outpad = s_out;
        tb_oe        = s_oe;
        tb_val       = s_val;
        #1;
    endtask

    // Full load: bit k of v ends in chain stage k, so stage TOT-1 goes first.
    task automatic load_cfg(input logic [TOT-1:0] v);
        for (int s = TOT - 1; s >= 0; s--) begin
            shift_bit(v[s]);
            if (s == TOT - 1) begin
                check("done_clr_on_rise", {31'd0, io.cfg_done}, 32'd0);
                check_isolated("reload");
            end
        end
        io.ccff_en   = 1'b0;
        io.ccff_head = 1'b0;
        tick();
        check("done_after_load", {31'd0, io.cfg_done}, 32'd1);
    endtask

    initial begin
        pReset       = 1'b1;
        io.ccff_en   = 1'b1;
        io.ccff_head = 1'b1;
        io.io_outpad = '0;
        tb_oe        = '0;
        tb_val       = '0;

        // Reset held two cycles while ccff_en is high: reset must win.
        tick();
        tick();
        check("rst_tail", {31'd0, io.ccff_tail}, 32'd0);
        check("rst_done", {31'd0, io.cfg_done}, 32'd0);
        check("rst_inpad", {24'd0, io.io_inpad}, 32'd0);
        pReset       = 1'b0;
        io.ccff_en   = 1'b0;
        io.ccff_head = 1'b0;
        check_isolated("rst");
        for (int i = 0; i < TOT - 1; i++) tail_q.push_back(1'b0);
        tick();
        check("idle_done", {31'd0, io.cfg_done}, 32'd0);

        // Chain passthrough with overshift: 1,0,1 then 24 zeros.
        shift_bit(1'b1);
        shift_bit(1'b0);
        shift_bit(1'b1);
        for (int i = 0; i < 24; i++) shift_bit(1'b0);
        io.ccff_en = 1'b0;
        tick();
        check("overshift_done", {31'd0, io.cfg_done}, 32'd1);
        // All-zero configuration: every slot is a combinational input.
        tb_oe  = '1;
        tb_val = 8'hA5;
        #1;
        check("comb_in_a5", {24'd0, io.io_inpad}, 32'h0000_00A5);
        tb_val = 8'h3C;
        #1;
        check("comb_in_3c", {24'd0, io.io_inpad}, 32'h0000_003C);

        // Slot 0 comb output, slot 1 registered input, slot 2 registered output.
        tb_val       = '0;
        tb_oe        = 8'hFA;
        io.io_outpad = 8'h01;
        load_cfg(24'h0000E1);
        check("pad0_out_same_cycle", {31'd0, gpio_pad[0]}, 32'd1);
        io.io_outpad[0] = 1'b0;
        #1;
        check("pad0_out_comb", {31'd0, gpio_pad[0]}, 32'd0);
        io.io_outpad[0] = 1'b1;
        check("inpad0_dir_out", {31'd0, io.io_inpad[0]}, 32'd0);
        check("inpad2_dir_out", {31'd0, io.io_inpad[2]}, 32'd0);
        tb_val[1] = 1'b1;
        #1;
        check("ireg_not_before", {31'd0, io.io_inpad[1]}, 32'd0);
        tick();
        check("ireg_after_1", {31'd0, io.io_inpad[1]}, 32'd1);
        tb_val[3] = 1'b1;
        #1;
        check("comb_in3", {31'd0, io.io_inpad[3]}, 32'd1);
        io.io_outpad[2] = 1'b1;
        #1;
        check("oreg_not_before", {31'd0, gpio_pad[2]}, 32'd0);
        tick();
        check("oreg_after_1", {31'd0, gpio_pad[2]}, 32'd1);
        io.io_outpad[2] = 1'b0;
        tick();
        check("oreg_fall", {31'd0, gpio_pad[2]}, 32'd0);

        // Reconfigure while slot 0 drives: slot 7 becomes a comb output and
        // slot 0 a comb input.
        tb_oe        = 8'h7A;
        tb_val       = '0;
        io.io_outpad = 8'h81;
        load_cfg(24'h200000);
        check("pad7_out", {31'd0, gpio_pad[7]}, 32'd1);
        tb_oe     = 8'h7F;
        tb_val[0] = 1'b1;
        #1;
        check("reconf_in0_hi", {31'd0, io.io_inpad[0]}, 32'd1);
        tb_val[0] = 1'b0;
        #1;
        check("reconf_in0_lo", {31'd0, io.io_inpad[0]}, 32'd0);

        // Partial load of 10 bits never completes a configuration.
        for (int i = 0; i < 10; i++) shift_bit(1'b1);
        io.ccff_en   = 1'b0;
        io.ccff_head = 1'b0;
        tick();
        check("partial_done_0", {31'd0, io.cfg_done}, 32'd0);
        tick();
        check("partial_done_1", {31'd0, io.cfg_done}, 32'd0);
        check_isolated("partial");

        // A following complete load recovers.
        load_cfg(24'h000000);
        tb_oe  = '1;
        tb_val = 8'h5A;
        #1;
        check("final_comb_in", {24'd0, io.io_inpad}, 32'h0000_005A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_grid_io_param
`default_nettype wire
